// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM encoding, angle constants, atan table and gain.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gain of an unbounded vectoring chain; downstream scaling divides by this.
  localparam real K_GAIN = 1.6467602581210654;

  // Quarter turn (pi/2) in a binary angle of the given width.
  function automatic logic [63:0] quarter(input int unsigned aw);
    return 64'd1 << (aw - 2);
  endfunction

  // atan(2^-i) with 2^31 LSB = pi, rounded.
  function automatic logic [31:0] atan_q31(input int unsigned i);
    case (i)
      0:  return 32'd536870912;
      1:  return 32'd316933406;
      2:  return 32'd167458907;
      3:  return 32'd85004756;
      4:  return 32'd42667331;
      5:  return 32'd21354465;
      6:  return 32'd10679838;
      7:  return 32'd5340245;
      8:  return 32'd2670163;
      9:  return 32'd1335087;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41722;
      15: return 32'd20861;
      16: return 32'd10430;
      17: return 32'd5215;
      18: return 32'd2608;
      19: return 32'd1304;
      20: return 32'd652;
      21: return 32'd326;
      22: return 32'd163;
      23: return 32'd81;
      24: return 32'd41;
      25: return 32'd20;
      26: return 32'd10;
      27: return 32'd5;
      28: return 32'd3;
      29: return 32'd1;
      30: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Rescale the Q31 table to an aw-bit binary angle (aw <= 32) with rounding.
  function automatic logic [63:0] atan_val(input int unsigned i, input int unsigned aw);
    logic [63:0] v;
    v = {32'd0, atan_q31(i)};
    if (aw >= 32) return v;
    return (v + (64'd1 << (31 - aw))) >> (32 - aw);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: i -> ATAN[i].
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 15,
  parameter int IDX_W       = 5
) (
  input  logic [IDX_W-1:0]       i_idx,
  output logic [ANGLE_WIDTH-1:0] o_atan
);

  always_comb begin
    o_atan = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (i_idx == IDX_W'(k)) o_atan = ANGLE_WIDTH'(atan_val(k, ANGLE_WIDTH));
    end
  end

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring engine: one micro-rotation per clock, returns
// uncompensated magnitude and binary angle atan2(y, x).
module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_WIDTH-1:0]  x_in,
  input  logic [WORD_WIDTH-1:0]  y_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WORD_WIDTH+1:0]  mag_out,
  output logic [ANGLE_WIDTH-1:0] angle_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int DW = WORD_WIDTH + 2;
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);
  localparam logic signed [ANGLE_WIDTH-1:0] QUARTER = ANGLE_WIDTH'(quarter(ANGLE_WIDTH));

  state_t r_state, w_next;

  logic signed [DW-1:0]          r_x, r_y;
  logic signed [ANGLE_WIDTH-1:0] r_z;
  logic [CW-1:0]                 r_i;
  logic [DW-1:0]                 r_mag;
  logic [ANGLE_WIDTH-1:0]        r_ang;

  logic signed [DW-1:0]          w_xin, w_yin, w_xn, w_yn;
  logic signed [ANGLE_WIDTH-1:0] w_zn;
  logic [ANGLE_WIDTH-1:0]        w_atan;
  logic                          w_accept, w_last;

  cordic_atan_rom #(
    .ANGLE_WIDTH(ANGLE_WIDTH),
    .ITERATIONS (ITERATIONS),
    .IDX_W      (CW)
  ) u_rom (
    .i_idx (r_i),
    .o_atan(w_atan)
  );

  // Widen before negating so -2^(WORD_WIDTH-1) survives the pre-rotation.
  assign w_xin    = DW'($signed(x_in));
  assign w_yin    = DW'($signed(y_in));
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_i == LAST);

  always_comb begin
    if (!r_y[DW-1]) begin
      w_xn = r_x + (r_y >>> r_i);
      w_yn = r_y - (r_x >>> r_i);
      w_zn = r_z + $signed(w_atan);
    end else begin
      w_xn = r_x - (r_y >>> r_i);
      w_yn = r_y + (r_x >>> r_i);
      w_zn = r_z - $signed(w_atan);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ITER;
      ITER:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_i   <= '0;
      r_mag <= '0;
      r_ang <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_i <= '0;
          if (!x_in[WORD_WIDTH-1]) begin
            r_x <= w_xin;
            r_y <= w_yin;
            r_z <= '0;
          end else if (!y_in[WORD_WIDTH-1]) begin
            r_x <= w_yin;
            r_y <= -w_xin;
            r_z <= QUARTER;
          end else begin
            r_x <= -w_yin;
            r_y <= w_xin;
            r_z <= -QUARTER;
          end
        end
        ITER: begin
          r_x <= w_xn;
          r_y <= w_yn;
          r_z <= w_zn;
          r_i <= r_i + 1'b1;
          if (w_last) begin
            r_mag <= w_xn;
            r_ang <= w_zn;
          end
        end
        default: ;
      endcase
    end
  end

  assign mag_out   = r_mag;
  assign angle_out = r_ang;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Randomised and directed bench for cordic_vector_iter against a real-valued atan2/hypot model.
module tb_cordic_vector_iter;
  import cordic_pkg::*;

  localparam int WW = 16;
  localparam int AW = 16;
  localparam int IT = 15;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [WW-1:0]        x_in = '0;
  logic [WW-1:0]        y_in = '0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic                 in_ready;
  logic                 out_valid;
  logic [WW+1:0]        mag_out;
  logic [AW-1:0]        angle_out;

  int n_err = 0;
  int n_chk = 0;

  cordic_vector_iter #(.WORD_WIDTH(WW), .ANGLE_WIDTH(AW), .ITERATIONS(IT)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_in     (x_in),
    .y_in     (y_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mag_out  (mag_out),
    .angle_out(angle_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // modbits > 0 compares modulo 2^modbits (angles wrap at +/-pi).
  task automatic chk(input string tag, input longint obs, input longint exp,
                     input longint tol = 0, input int modbits = 0);
    longint d;
    d = obs - exp;
    if (modbits > 0) begin
      d = d & ((64'sd1 <<< modbits) - 1);
      if (d >= (64'sd1 <<< (modbits - 1))) d = d - (64'sd1 <<< modbits);
    end
    n_chk++;
    if (d > tol || d < -tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input longint xv, input longint yv, output longint m, output longint a);
    real r;
    r = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)) * K_GAIN;
    m = longint'(r);
    a = longint'($atan2(real'(yv), real'(xv)) * 32768.0 / PI);
  endtask

  function automatic longint ang_s();
    return longint'($signed(angle_out));
  endfunction

  // Present one vector, wait for the result and check latency, magnitude, angle.
  task automatic run_vec(input string tag, input int xv, input int yv,
                         input longint emag, input longint eang);
    int cnt;
    chk({tag, ".rdy"}, longint'(in_ready), 1);
    x_in = WW'(xv);
    y_in = WW'(yv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, ".lat"}, cnt, IT);
    chk({tag, ".mag"}, longint'(mag_out), emag, 8);
    chk({tag, ".ang"}, ang_s(), eang, 4, AW);
    if (out_ready) begin
      tick();
      chk({tag, ".ovd"}, longint'(out_valid), 0);
      chk({tag, ".ird"}, longint'(in_ready), 1);
    end
  endtask

  initial begin
    longint em, ea, xr, yr;

    // reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst.ird", longint'(in_ready), 1);
    chk("rst.ovd", longint'(out_valid), 0);
    chk("rst.mag", longint'(mag_out), 0);
    chk("rst.ang", ang_s(), 0);
    rst = 1'b1;
    tick();
    chk("rel.ird", longint'(in_ready), 1);

    // directed cases with known answers
    run_vec("px",   16384,      0, 26981,      0);
    run_vec("py",       0,  16384, 26981,  16384);
    run_vec("q1",   16384,  16384, 38158,   8192);
    run_vec("q3",  -16384, -16384, 38158, -24576);
    run_vec("nx",  -16384,      0, 26981,  32768);
    run_vec("min", -32768, -32768, 76317, -24576);
    model(-20000, 12000, em, ea);
    run_vec("q2",  -20000,  12000, em, ea);

    // zero vector: angle is implementation-defined, magnitude ~0
    x_in = '0;
    y_in = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
        tick();
        cnt++;
      end
      chk("zero.lat", cnt, IT);
      chk("zero.mag", longint'(mag_out), 0, 2);
    end
    tick();

    // backpressure: outputs held, in_valid ignored while DONE
    out_ready = 1'b0;
    run_vec("bp", 16384, 16384, 38158, 8192);
    for (int k = 0; k < 5; k++) begin
      x_in = WW'($urandom);
      y_in = WW'($urandom);
      in_valid = 1'b1;
      tick();
      chk("bp.ovd", longint'(out_valid), 1);
      chk("bp.ird", longint'(in_ready), 0);
      chk("bp.mag", longint'(mag_out), 38158, 8);
      chk("bp.ang", ang_s(), 8192, 4, AW);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp.rel.ovd", longint'(out_valid), 0);
    chk("bp.rel.ird", longint'(in_ready), 1);
    tick();
    chk("bp.idle", longint'(in_ready), 1);

    // reset in the middle of an iteration sequence
    x_in = WW'(12000);
    y_in = WW'(-20000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid.ovd", longint'(out_valid), 0);
    chk("mid.mag", longint'(mag_out), 0);
    chk("mid.ang", ang_s(), 0);
    chk("mid.ird", longint'(in_ready), 1);
    model(-9000, 25000, em, ea);
    run_vec("post", -9000, 25000, em, ea);

    // randomised vectors against the real-valued model
    for (int n = 0; n < 24; n++) begin
      do begin
        xr = longint'($signed(WW'($urandom)));
        yr = longint'($signed(WW'($urandom)));
      end while (xr * xr + yr * yr < 64'd268435456);
      model(xr, yr, em, ea);
      run_vec("rnd", int'(xr), int'(yr), em, ea);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_vector_iter.md
Name: cordic_vector_iter

Overview:
Iterative CORDIC vectoring engine. Accepts a signed (x, y) vector and performs one micro-rotation per clock. Drives y toward zero and returns the uncompensated magnitude and the binary angle. Sits directly upstream of the output pipeline registers, which capture mag_out/angle_out on the output handshake.

Parameters:
WORD_WIDTH, 16, width of signed x_in/y_in
ANGLE_WIDTH, 16, width of signed binary angle; 2^(ANGLE_WIDTH-1) LSB = pi
ITERATIONS, 15, number of micro-rotations (i = 0..ITERATIONS-1); must be <= WORD_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-low reset
x_in  input  WORD_WIDTH  signed x component
y_in  input  WORD_WIDTH  signed y component
in_valid  input  1  x_in/y_in valid
in_ready  output  1  engine can accept a vector
mag_out  output  WORD_WIDTH+2  unsigned magnitude, scaled by CORDIC gain K~1.6468
angle_out  output  ANGLE_WIDTH  signed binary angle atan2(y,x)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result

Behaviour:
- Reset: synchronous, active when rst=0 at a clk edge. Overrides every other event, including an in-flight computation, which is discarded.
- Reset values: state=IDLE, x/y/z regs=0, iteration counter=0, mag_out=0, angle_out=0, out_valid=0.
- in_ready = (state==IDLE), combinational from state. It is therefore 1 in the first cycle after reset releases.
- Internal x, y datapath is WORD_WIDTH+2 bits signed. Inputs are sign-extended before any negation, so -2^(WORD_WIDTH-1) is legal. z is ANGLE_WIDTH bits signed and wraps modulo 2pi.
- State IDLE, on in_valid & in_ready: load with quadrant pre-rotation, then go to ITER with i=0.
  - x_in >= 0: x=x_in, y=y_in, z=0.
  - x_in < 0 and y_in >= 0: x=y_in, y=-x_in, z=+QUARTER (2^(ANGLE_WIDTH-2)).
  - x_in < 0 and y_in < 0: x=-y_in, y=x_in, z=-QUARTER.
- State ITER, each cycle, with arithmetic shifts:
  - y >= 0: x <= x + (y>>>i); y <= y - (x>>>i); z <= z + ATAN[i].
  - y < 0: x <= x - (y>>>i); y <= y + (x>>>i); z <= z - ATAN[i].
  - ATAN[i] = round(atan(2^-i) * 2^(ANGLE_WIDTH-1)/pi).
  - i increments each cycle. The cycle with i==ITERATIONS-1 registers mag_out=x[WORD_WIDTH+1:0] and angle_out=z, sets out_valid=1, and goes to DONE.
- State DONE: out_valid=1; mag_out and angle_out are held stable. On out_ready=1: out_valid<=0, go to IDLE. in_valid is ignored outside IDLE.
- Latency: vector accepted at edge T produces out_valid=1 after edge T+ITERATIONS. Throughput is one vector per ITERATIONS+2 cycles with out_ready held high.
- mag_out is never compensated for K; the downstream stage applies scaling.
- Zero vector (0,0): angle_out is whatever the iteration yields (defined: 0 +/- ATAN sums), mag_out=0 +/- 2 LSB. Not an error.

Decomposition:
- Shared package cordic_pkg holds:
  - state encoding IDLE/ITER/DONE;
  - the QUARTER constant;
  - the ATAN table as a function of (i, ANGLE_WIDTH), or a constant array for the defaults;
  - the K gain constant, for benches.
- One natural sub-module: cordic_atan_rom (combinational i -> ATAN[i]), shared with any future rotation-mode engine.

Test Plan:
Tolerances: angle +/-4 LSB, mag +/-8 LSB; all cases use default parameters.
1. (x,y)=(16384,0) -> angle_out=0, mag_out=26981; out_valid exactly 15 cycles after the accept edge.
2. (0,16384) -> angle_out=16384 (0x4000), mag_out=26981.
3. (16384,16384) -> angle_out=8192, mag_out=38158. (-16384,-16384) -> angle_out=-24576, mag_out=38158.
4. (-16384,0) -> angle_out=0x8000 modulo wrap (+/-4 LSB), mag_out=26981. (-32768,-32768) -> no overflow, mag_out=76317, angle_out=-24576.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Release -> out_valid drops next edge, in_ready=1 the cycle after.
6. Reset mid-operation: rst=0 for one edge at i=7 -> next cycle out_valid=0, mag_out=0, angle_out=0, in_ready=1. A new vector is then processed correctly with no residue from the aborted one.
